// File: rtl/axil_arb_pkg.sv
// Shared types and the round-robin search used by the AXI-Lite read arbiter.
package axil_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Widest request vector rr_pick handles (NUM_MASTERS tops out at 16).
  localparam int RR_MAX = 16;

  // First set bit of req at or after ptr, wrapping at n. Returns ptr when
  // nothing is requested so the grant stays parked on the pointer.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    logic       found;
    logic [3:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = 4'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arb_rr_locked.sv
// Round-robin picker with a grant lock: once AR is presented without
// arready the grant freezes until the handshake, keeping araddr stable.
module arb_rr_locked
  import axil_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int MIW = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic           arvalid_i,
  input  logic           arready_i,
  output logic [MIW-1:0] grant_o,
  output logic           locked_o
);

  arb_state_e     state_q, state_d;
  logic [MIW-1:0] ptr_q, ptr_d;
  logic [MIW-1:0] lgrant_q, lgrant_d;
  logic [MIW-1:0] pick;

  assign pick     = MIW'(rr_pick(RR_MAX'(req_i), 4'(ptr_q), N));
  assign locked_o = (state_q == ARB_LOCKED);
  assign grant_o  = locked_o ? lgrant_q : pick;

  // Handshake releases the lock and advances the pointer past the winner;
  // an unaccepted arvalid captures the current grant into the lock.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lgrant_d = lgrant_q;
    if (arvalid_i && arready_i) begin
      state_d = ARB_IDLE;
      ptr_d   = (grant_o == MIW'(N - 1)) ? '0 : grant_o + 1'b1;
    end else if (arvalid_i) begin
      state_d  = ARB_LOCKED;
      lgrant_d = grant_o;
    end
  end

  // Lock, locked grant and RR pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      lgrant_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lgrant_q <= lgrant_d;
    end
  end

endmodule

// File: rtl/axil4_rd_arbiter.sv
// N-to-1 AXI4-Lite read arbiter. AR is arbitrated round-robin with a lock;
// an in-order FIFO of grant indices steers each R beat back to its issuer.
module axil4_rd_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [NUM_MASTERS*AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [NUM_MASTERS*3-1:0]               s_axil_arprot,
  input  logic [NUM_MASTERS-1:0]                 s_axil_arvalid,
  output logic [NUM_MASTERS-1:0]                 s_axil_arready,
  output logic [NUM_MASTERS*AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [NUM_MASTERS*2-1:0]               s_axil_rresp,
  output logic [NUM_MASTERS-1:0]                 s_axil_rvalid,
  input  logic [NUM_MASTERS-1:0]                 s_axil_rready,
  output logic [AXIL_ADDR_WIDTH-1:0]             m_axil_araddr,
  output logic [2:0]                             m_axil_arprot,
  output logic                                   m_axil_arvalid,
  input  logic                                   m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]             m_axil_rdata,
  input  logic [1:0]                             m_axil_rresp,
  input  logic                                   m_axil_rvalid,
  output logic                                   m_axil_rready,
  input  logic [NUM_MASTERS-1:0]                 cfg_master_enable,
  output logic [$clog2(NUM_MASTERS)-1:0]         grant_id,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_count,
  output logic                                   busy,
  output logic                                   err_unexpected_r
);

  localparam int AW  = AXIL_ADDR_WIDTH;
  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_MASTERS-1:0] req;
  logic [MIW-1:0]         grant, head;
  logic                   locked, arv_sel, head_rready;
  logic                   full, empty, push, pop;

  logic [MIW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  assign req   = s_axil_arvalid & cfg_master_enable;
  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  arb_rr_locked #(.N(NUM_MASTERS), .MIW(MIW)) u_arb (
    .clk_i     (aclk),
    .rst_i     (areset),
    .req_i     (req),
    .arvalid_i (m_axil_arvalid),
    .arready_i (m_axil_arready),
    .grant_o   (grant),
    .locked_o  (locked)
  );

  // AR mux from the granted master and one-hot steering of arready/rvalid.
  // A locked grant follows raw arvalid so disabling it cannot retract AR.
  always_comb begin
    arv_sel        = 1'b0;
    head_rready    = 1'b0;
    m_axil_araddr  = '0;
    m_axil_arprot  = '0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant == MIW'(i)) begin
        arv_sel           = locked ? s_axil_arvalid[i] : req[i];
        m_axil_araddr     = s_axil_araddr[i*AW +: AW];
        m_axil_arprot     = s_axil_arprot[i*3 +: 3];
        s_axil_arready[i] = !areset && m_axil_arready && !full;
      end
      if (head == MIW'(i)) begin
        head_rready      = s_axil_rready[i];
        s_axil_rvalid[i] = !areset && m_axil_rvalid && !empty;
      end
    end
  end

  assign m_axil_arvalid = !areset && arv_sel && !full;
  assign m_axil_rready  = !areset && head_rready && !empty;
  assign push           = m_axil_arvalid && m_axil_arready;
  assign pop            = m_axil_rvalid && m_axil_rready;

  assign s_axil_rdata = {NUM_MASTERS{m_axil_rdata}};
  assign s_axil_rresp = {NUM_MASTERS{m_axil_rresp}};

  assign grant_id          = areset ? '0 : grant;
  assign outstanding_count = cnt_q;
  assign err_unexpected_r  = err_q;
  assign busy              = (|s_axil_arvalid) || locked || !empty;

  // Grant-FIFO pointer/occupancy next state and the sticky stray-R flag.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q || (m_axil_rvalid && empty);
    if (push) wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers; reset drops all in-flight routing.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // FIFO storage: records which master issued each accepted AR.
  always_ff @(posedge aclk) begin
    if (push) fifo_q[wptr_q] <= grant;
  end

endmodule
